// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one apb_master command port among NUM_REQ requesters,
// with one-shot start pulse, held command, routed response and a WAIT watchdog.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                    apb_clk,
    input  logic                    apb_reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [8*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_wdata,
    input  logic [NUM_REQ-1:0]      req_dir,
    output logic [NUM_REQ-1:0]      rsp_done,
    output logic                    rsp_err,
    output logic [31:0]             rsp_rdata,
    output logic [NUM_REQ-1:0]      grant,
    output logic [7:0]              m_addr,
    output logic [31:0]             m_data,
    output logic                    m_data_dir,
    output logic                    m_data_valid,
    input  logic [31:0]             m_read_out_data,
    input  logic                    m_transaction_done,
    input  logic                    m_tranerr
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WAIT_LIMIT - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, rsp_done_q, rsp_done_d;
    logic                rsp_err_q, rsp_err_d, m_dir_q, m_dir_d, m_valid_q, m_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d, m_data_q, m_data_d;
    logic [7:0]          m_addr_q, m_addr_d;
    logic [WW-1:0]       wd_q, wd_d;
    logic [IW-1:0]       last_q, last_d, win;
    logic                found;
    logic [7:0]          addr_a  [NUM_REQ];
    logic [31:0]         wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[8*g +: 8];
        assign wdata_a[g] = req_wdata[32*g +: 32];
    end

    // explicit wrap keeps the candidate index below NUM_REQ for any requester count
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[rr_idx(last_q, k)]) begin
                found = 1'b1;
                win   = rr_idx(last_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rsp_done_d  = rsp_done_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        m_dir_d     = m_dir_q;
        m_valid_d   = m_valid_q;
        wd_d        = wd_q;
        last_d      = last_q;
        case (state_q)
            IDLE: if (found) begin
                state_d   = ISSUE;
                grant_d   = NUM_REQ'(1) << win;
                m_addr_d  = addr_a[win];
                m_dir_d   = req_dir[win];
                m_data_d  = req_dir[win] ? wdata_a[win] : '0;
                m_valid_d = 1'b1;
                last_d    = win;
            end
            ISSUE: begin
                state_d   = WAIT;
                m_valid_d = 1'b0;
                wd_d      = '0;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // done outranks tranerr, which outranks the watchdog
                if (m_transaction_done || m_tranerr || wd_q == WD_MAX) begin
                    state_d     = RESP;
                    rsp_done_d  = grant_q;
                    rsp_err_d   = !m_transaction_done;
                    rsp_rdata_d = (m_transaction_done && !m_dir_q) ? m_read_out_data : '0;
                end
            end
            RESP: begin
                state_d     = IDLE;
                grant_d     = '0;
                rsp_done_d  = '0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or posedge apb_reset) begin
        if (apb_reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            m_dir_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            wd_q        <= '0;
            last_q      <= LAST_RST;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            m_dir_q     <= m_dir_d;
            m_valid_q   <= m_valid_d;
            wd_q        <= wd_d;
            last_q      <= last_d;
        end
    end

    assign grant        = grant_q;
    assign rsp_done     = rsp_done_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign m_addr       = m_addr_q;
    assign m_data       = m_data_q;
    assign m_data_dir   = m_dir_q;
    assign m_data_valid = m_valid_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table vectors, hand sequences and random traffic against a transaction-level model,
// with a behavioural apb_master stand-in driving done/tranerr/read data.
module tb_apb_req_arbiter;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [8*NR-1:0]  req_addr = '0;
    logic [32*NR-1:0] req_wdata = '0;
    logic [NR-1:0]  req_dir = '0;
    logic [NR-1:0]  rsp_done, grant;
    logic           rsp_err, m_data_dir, m_data_valid;
    logic [31:0]    rsp_rdata, m_data;
    logic [7:0]     m_addr;
    logic [31:0]    m_rdata = '0;
    logic           m_done = 1'b0, m_err = 1'b0;

    apb_req_arbiter #(.NUM_REQ(NR), .WAIT_LIMIT(8)) dut (
        .apb_clk(clk), .apb_reset(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_dir(req_dir), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .grant(grant),
        .m_addr(m_addr), .m_data(m_data), .m_data_dir(m_data_dir), .m_data_valid(m_data_valid),
        .m_read_out_data(m_rdata), .m_transaction_done(m_done), .m_tranerr(m_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int s_mode = 0, s_lat = 0;
    logic [7:0]  pa [NR];
    logic [31:0] pw [NR];
    logic        pd [NR];
    logic [7:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    logic        e_dir = 1'b0;
    logic [31:0] smem [256];
    logic [31:0] ref_mem [8];

    typedef struct {
        logic [3:0]  mask;
        logic        dir;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          mode;
        int          lat;
        int          idx;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } vec_t;
    vec_t tv [12];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic pack();
        req_addr  = {pa[3], pa[2], pa[1], pa[0]};
        req_wdata = {pw[3], pw[2], pw[1], pw[0]};
        req_dir   = {pd[3], pd[2], pd[1], pd[0]};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_done == '0 && cyc < 40);
        chk("done_seen", 32'(rsp_done != '0), 1);
    endtask

    task automatic check_txn(input string t, input logic [3:0] mask, input int idx, input logic err,
                             input logic [31:0] rdata, input int cyc_exp);
        int cyc;
        req = mask;
        wait_done(cyc);
        req = '0;
        chk({t, "_done"}, rsp_done, 32'(1) << idx);
        chk({t, "_grant"}, grant, 32'(1) << idx);
        chk({t, "_err"}, rsp_err, err);
        chk({t, "_rdata"}, rsp_rdata, rdata);
        chk({t, "_latency"}, cyc, cyc_exp);
        @(negedge clk);
        chk({t, "_clear"}, {rsp_done, grant, 3'b0, rsp_err}, 0);
        chk({t, "_clear_rdata"}, rsp_rdata, 0);
    endtask

    // apb_master stand-in: responds s_lat cycles into WAIT according to s_mode
    // (0 done, 1 tranerr, 2 never, 3 done and tranerr together)
    initial begin
        logic [7:0] a;
        logic [31:0] d;
        logic w;
        for (int i = 0; i < 256; i++) smem[i] = '0;
        forever begin
            @(negedge clk);
            if (m_data_valid) begin
                a = m_addr;
                d = m_data;
                w = m_data_dir;
                repeat (s_lat + 1) @(negedge clk);
                if (s_mode != 2) begin
                    m_done  = (s_mode != 1);
                    m_err   = (s_mode != 0);
                    m_rdata = $urandom;
                    if (s_mode != 1) begin
                        if (w) smem[a] = d;
                        else m_rdata = smem[a];
                    end
                    @(negedge clk);
                    m_done  = 1'b0;
                    m_err   = 1'b0;
                    m_rdata = $urandom;
                end
            end
        end
    end

    // command must match the expected winner from the start pulse until completion
    initial begin
        logic prev_valid, holding;
        prev_valid = 1'b0;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (m_data_valid) chk("valid_one_cycle", 32'(prev_valid), 0);
                if (m_data_valid || holding) begin
                    chk("m_addr", m_addr, e_addr);
                    chk("m_data", m_data, e_data);
                    chk("m_data_dir", m_data_dir, e_dir);
                end
                if (m_data_valid) holding = 1'b1;
                if (rsp_done != '0) holding = 1'b0;
                prev_valid = m_data_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int cyc, rlast, j, r;
        logic [3:0] mask;
        logic to, er;
        logic [31:0] exp_rd;
        tv[0]  = '{4'b0001, 1'b1, 8'd4, 32'd10,        0, 0, 0, 1'b0, 32'd0,        3};
        tv[1]  = '{4'b0010, 1'b1, 8'd5, 32'd12,        0, 1, 1, 1'b0, 32'd0,        4};
        tv[2]  = '{4'b0010, 1'b0, 8'd5, 32'd0,         0, 2, 1, 1'b0, 32'd12,       5};
        tv[3]  = '{4'b0110, 1'b0, 8'd4, 32'd0,         0, 0, 2, 1'b0, 32'd10,       3};
        tv[4]  = '{4'b0101, 1'b1, 8'd6, 32'd99,        1, 3, 0, 1'b1, 32'd0,        6};
        tv[5]  = '{4'b0101, 1'b0, 8'd6, 32'd0,         0, 0, 2, 1'b0, 32'd0,        3};
        tv[6]  = '{4'b1111, 1'b0, 8'd4, 32'd0,         2, 0, 3, 1'b1, 32'd0,        10};
        tv[7]  = '{4'b1001, 1'b0, 8'd4, 32'd0,         0, 7, 0, 1'b0, 32'd10,       10};
        tv[8]  = '{4'b1000, 1'b0, 8'd5, 32'd0,         1, 0, 3, 1'b1, 32'd0,        3};
        tv[9]  = '{4'b1000, 1'b1, 8'd7, 32'hDEADBEEF,  0, 6, 3, 1'b0, 32'd0,        9};
        tv[10] = '{4'b0001, 1'b0, 8'd7, 32'd0,         0, 0, 0, 1'b0, 32'hDEADBEEF, 3};
        tv[11] = '{4'b0010, 1'b0, 8'd7, 32'd0,         3, 0, 1, 1'b0, 32'hDEADBEEF, 3};
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;

        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_rsp_done", rsp_done, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_data_dir", m_data_dir, 0);
        chk("rst_m_data_valid", m_data_valid, 0);

        // all requesters held high: grants rotate 0,1,2,3,0 with one IDLE cycle between
        for (int i = 0; i < NR; i++) begin pa[i] = 8'(8'h20 + i); pw[i] = '0; pd[i] = 1'b0; end
        pack();
        s_mode = 0; s_lat = 0;
        e_addr = 8'h20; e_data = '0; e_dir = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(cyc);
            chk("rr_done", rsp_done, 32'(1) << (n % NR));
            chk("rr_gap", cyc, n == 0 ? 3 : 4);
            e_addr = 8'(8'h20 + (n + 1) % NR);
            if (n == 4) req = '0;
        end
        repeat (2) @(negedge clk);

        // asynchronous reset while stuck in WAIT
        for (int i = 0; i < NR; i++) pa[i] = 8'h30;
        pack();
        e_addr = 8'h30;
        s_mode = 2; s_lat = 0;
        req = 4'b0100;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_m_valid_dir", {m_data_valid, m_data_dir}, 0);
        chk("arst_m_addr", m_addr, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_rsp", {rsp_done, 3'b0, rsp_err}, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        s_mode = 0;
        req = 4'b1111;
        @(negedge clk);
        chk("arst_first_grant", grant, 4'b0001);
        chk("arst_first_valid", m_data_valid, 1);
        wait_done(cyc);
        req = '0;
        chk("arst_first_done", rsp_done, 4'b0001);
        chk("arst_first_err", rsp_err, 0);
        @(negedge clk);

        do_reset();
        foreach (tv[v]) begin
            for (int i = 0; i < NR; i++) begin pa[i] = tv[v].addr; pw[i] = tv[v].wdata; pd[i] = tv[v].dir; end
            pack();
            s_mode = tv[v].mode; s_lat = tv[v].lat;
            e_addr = tv[v].addr; e_dir = tv[v].dir; e_data = tv[v].dir ? tv[v].wdata : '0;
            check_txn($sformatf("vec%0d", v), tv[v].mask, tv[v].idx, tv[v].err, tv[v].rdata, tv[v].cyc);
        end

        // random traffic against a transaction-level model
        do_reset();
        rlast = NR - 1;
        for (int it = 0; it < 150; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) begin
                pa[i] = 8'(16 + $urandom_range(0, 7));
                pw[i] = $urandom;
                pd[i] = 1'($urandom_range(0, 1));
            end
            pack();
            r = $urandom_range(0, 9);
            s_mode = r <= 6 ? 0 : r == 7 ? 1 : r == 8 ? 3 : 2;
            s_lat = $urandom_range(0, 7);
            j = -1;
            for (int k = 1; k <= NR; k++) if (j < 0 && mask[(rlast + k) % NR]) j = (rlast + k) % NR;
            to = (s_mode == 2);
            er = to || s_mode == 1;
            exp_rd = (!er && !pd[j]) ? ref_mem[pa[j][2:0]] : '0;
            if (!er && pd[j]) ref_mem[pa[j][2:0]] = pw[j];
            e_addr = pa[j]; e_dir = pd[j]; e_data = pd[j] ? pw[j] : '0;
            check_txn("rnd", mask, j, er, exp_rd, to ? 10 : 3 + s_lat);
            rlast = j;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
